// File: rtl/pong_game_ctrl_if.sv
// Pong game-controller bundle: control inputs from the frame/board logic and
// the sequencer's outputs toward the ball datapath and the score overlay.
interface pong_game_ctrl_if #(
   parameter int SCORE_W = 4
);
   logic               enable;
   logic               frameTick;
   logic               serveBtn;
   logic               missLeft;
   logic               missRight;
   logic               ballRun;
   logic               ballCenter;
   logic               serveDir;
   logic [SCORE_W-1:0] scoreLeft;
   logic [SCORE_W-1:0] scoreRight;
   logic               gameOver;
   logic               winner;
   logic [2:0]         state;

   // Side that drives the game inputs and observes the sequencer
   modport master (
      output enable, frameTick, serveBtn, missLeft, missRight,
      input  ballRun, ballCenter, serveDir, scoreLeft, scoreRight,
             gameOver, winner, state
   );

   // The game sequencer itself
   modport slave (
      input  enable, frameTick, serveBtn, missLeft, missRight,
      output ballRun, ballCenter, serveDir, scoreLeft, scoreRight,
             gameOver, winner, state
   );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve / play / point / game-over flow, score keeping,
// ball gating and frame-paced pauses.
module pong_game_ctrl #(
   parameter int WIN_SCORE    = 7,
   parameter int SCORE_W      = 4,
   parameter int SERVE_FRAMES = 60,
   parameter int POINT_FRAMES = 90
) (
   input  logic            clk,
   input  logic            rst,     // asynchronous, active low
   pong_game_ctrl_if.slave bus
);

   localparam int CNT_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES);
   localparam logic [CNT_W-1:0]   POINT_LOAD = CNT_W'(POINT_FRAMES);
   localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(1);
   localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SERVE = 3'd1,
      S_PLAY  = 3'd2,
      S_POINT = 3'd3,
      S_OVER  = 3'd4
   } state_t;

   state_t             r_state,       w_state_nx;
   logic [CNT_W-1:0]   r_cnt,         w_cnt_nx;
   logic [SCORE_W-1:0] r_score_left,  w_score_left_nx;
   logic [SCORE_W-1:0] r_score_right, w_score_right_nx;
   logic               r_center,      w_center_nx;
   logic               r_serve_dir,   w_serve_dir_nx;
   logic               r_game_over,   w_game_over_nx;
   logic               r_winner,      w_winner_nx;
   logic               r_btn_q;
   logic               w_btn_rise;

   // Button history tracks the input every cycle, enabled or not, so that
   // re-enabling with the button held never looks like a fresh press.
   assign w_btn_rise = bus.serveBtn && !r_btn_q;

   // State, counter, scores and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_score_left  <= '0;
         r_score_right <= '0;
         r_center      <= 1'b0;
         r_serve_dir   <= 1'b0;
         r_game_over   <= 1'b0;
         r_winner      <= 1'b0;
         r_btn_q       <= 1'b0;
      end else begin
         r_state       <= w_state_nx;
         r_cnt         <= w_cnt_nx;
         r_score_left  <= w_score_left_nx;
         r_score_right <= w_score_right_nx;
         r_center      <= w_center_nx;
         r_serve_dir   <= w_serve_dir_nx;
         r_game_over   <= w_game_over_nx;
         r_winner      <= w_winner_nx;
         r_btn_q       <= bus.serveBtn;
      end
   end

   // Next-state and next-output logic; everything holds while disabled
   always_comb begin
      w_state_nx       = r_state;
      w_cnt_nx         = r_cnt;
      w_score_left_nx  = r_score_left;
      w_score_right_nx = r_score_right;
      w_center_nx      = 1'b0;
      w_serve_dir_nx   = r_serve_dir;
      w_game_over_nx   = r_game_over;
      w_winner_nx      = r_winner;

      if (bus.enable) begin
         case (r_state)
            S_IDLE: begin
               if (w_btn_rise) begin
                  w_score_left_nx  = '0;
                  w_score_right_nx = '0;
                  w_center_nx      = 1'b1;
                  w_cnt_nx         = SERVE_LOAD;
                  w_state_nx       = S_SERVE;
               end
            end

            S_SERVE: begin
               if (bus.frameTick) begin
                  if (r_cnt == CNT_LAST) begin
                     w_state_nx = S_PLAY;
                  end else begin
                     w_cnt_nx = r_cnt - 1'b1;
                  end
               end
            end

            S_PLAY: begin
               if (bus.missLeft || bus.missRight) begin
                  if (bus.missLeft && bus.missRight) begin
                     // Simultaneous misses: no point, swap who serves
                     w_serve_dir_nx = !r_serve_dir;
                  end else if (bus.missLeft) begin
                     w_score_right_nx = r_score_right + 1'b1;
                     w_serve_dir_nx   = 1'b0;
                  end else begin
                     w_score_left_nx = r_score_left + 1'b1;
                     w_serve_dir_nx  = 1'b1;
                  end
                  w_cnt_nx   = POINT_LOAD;
                  w_state_nx = S_POINT;
               end
            end

            S_POINT: begin
               if (bus.frameTick) begin
                  if (r_cnt == CNT_LAST) begin
                     if (r_score_left == WIN_VAL) begin
                        w_winner_nx    = 1'b0;
                        w_game_over_nx = 1'b1;
                        w_state_nx     = S_OVER;
                     end else if (r_score_right == WIN_VAL) begin
                        w_winner_nx    = 1'b1;
                        w_game_over_nx = 1'b1;
                        w_state_nx     = S_OVER;
                     end else begin
                        w_center_nx = 1'b1;
                        w_cnt_nx    = SERVE_LOAD;
                        w_state_nx  = S_SERVE;
                     end
                  end else begin
                     w_cnt_nx = r_cnt - 1'b1;
                  end
               end
            end

            S_OVER: begin
               if (w_btn_rise) begin
                  w_score_left_nx  = '0;
                  w_score_right_nx = '0;
                  w_game_over_nx   = 1'b0;
                  w_center_nx      = 1'b1;
                  w_cnt_nx         = SERVE_LOAD;
                  w_state_nx       = S_SERVE;
               end
            end

            default: begin
               w_state_nx = S_IDLE;
            end
         endcase
      end
   end

   assign bus.ballRun    = (r_state == S_PLAY) && bus.enable;
   assign bus.ballCenter = r_center;
   assign bus.serveDir   = r_serve_dir;
   assign bus.scoreLeft  = r_score_left;
   assign bus.scoreRight = r_score_right;
   assign bus.gameOver   = r_game_over;
   assign bus.winner     = r_winner;
   assign bus.state      = r_state;

endmodule
